// File: rtl/fpu_muladd_issuer.sv
// fpu_muladd_issuer: issues fused-multiply-add operand triples to a
// valid-only FPU pipeline and collects its valid-only result stream into a
// local FIFO that is presented on a ready/valid output.
//
// The FPU offers no back-pressure, so an operation is only issued when a
// FIFO slot is guaranteed for its result: the sum of operations in flight
// and results already buffered must stay below DEPTH. This makes FIFO
// overflow impossible whatever the FPU latency.
module fpu_muladd_issuer #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          aclk,
    input  logic          areset,
    // operand stream from the producer
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [31:0]   op_a,
    input  logic [31:0]   op_b,
    input  logic [31:0]   op_c,
    // operand bus to the FPU
    output logic [31:0]   m_axis_a_tdata,
    output logic [31:0]   m_axis_b_tdata,
    output logic [31:0]   m_axis_c_tdata,
    output logic          m_axis_abc_tvalid,
    // result bus from the FPU
    input  logic          s_axis_result_tvalid,
    input  logic [31:0]   s_axis_result_tdata,
    // result stream to the consumer
    output logic          res_valid,
    input  logic          res_ready,
    output logic [31:0]   res_data,
    // status
    output logic [CW-1:0] inflight,
    output logic          err_spurious
);

    // Pointer width; DEPTH is a power of two so pointers wrap naturally.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Credit limit expressed in the widened credit-sum width.
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Advance a FIFO pointer by one slot, wrapping modulo DEPTH.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return p + AW'(1'b1);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   a_r;
    logic [31:0]   b_r;
    logic [31:0]   c_r;
    logic          tvalid_r;

    logic [CW-1:0] inflight_r;
    logic [CW-1:0] fifo_cnt_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [31:0]   mem_r [DEPTH];

    logic          res_valid_r;
    logic [31:0]   res_data_r;
    logic          err_r;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [CW:0]   credits_used_s;
    logic          op_ready_s;
    logic          accept_s;
    logic          push_s;
    logic          spurious_s;
    logic          pop_s;

    logic [CW-1:0] inflight_nxt_s;
    logic [CW-1:0] fifo_cnt_nxt_s;
    logic [AW-1:0] wr_ptr_nxt_s;
    logic [AW-1:0] rd_ptr_nxt_s;
    logic [31:0]   head_nxt_s;

    // Credit check and handshake decode, all from registered state.
    always_comb begin
        credits_used_s = {1'b0, inflight_r} + {1'b0, fifo_cnt_r};
        if (areset) begin
            op_ready_s = 1'b0;
        end else begin
            op_ready_s = (credits_used_s < DEPTH_W);
        end
        accept_s   = op_valid && op_ready_s;
        // A result only belongs to us if something is actually outstanding.
        push_s     = s_axis_result_tvalid && (inflight_r != {CW{1'b0}});
        spurious_s = s_axis_result_tvalid && (inflight_r == {CW{1'b0}});
        pop_s      = res_valid_r && res_ready;
    end

    // Outstanding-operation count: +1 on issue, -1 on a result return.
    always_comb begin
        inflight_nxt_s = inflight_r;
        case ({accept_s, push_s})
            2'b10:   inflight_nxt_s = inflight_r + CW'(1'b1);
            2'b01:   inflight_nxt_s = inflight_r - CW'(1'b1);
            default: inflight_nxt_s = inflight_r;
        endcase
    end

    // FIFO occupancy: +1 on capture, -1 on consumer pop.
    always_comb begin
        fifo_cnt_nxt_s = fifo_cnt_r;
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + CW'(1'b1);
            2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - CW'(1'b1);
            default: fifo_cnt_nxt_s = fifo_cnt_r;
        endcase
    end

    // Next pointers and the word that will sit at the FIFO head.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        head_nxt_s   = 32'h0000_0000;
        if (push_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        // The new head is either an already-stored entry or, when the
        // slot being written this cycle becomes the head, the incoming
        // result word itself.
        if (fifo_cnt_nxt_s == {CW{1'b0}}) begin
            head_nxt_s = 32'h0000_0000;
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = s_axis_result_tdata;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Issue stage: capture an accepted triple and pulse tvalid for one cycle.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            a_r      <= 32'h0000_0000;
            b_r      <= 32'h0000_0000;
            c_r      <= 32'h0000_0000;
            tvalid_r <= 1'b0;
        end else begin
            tvalid_r <= accept_s;
            if (accept_s) begin
                a_r <= op_a;
                b_r <= op_b;
                c_r <= op_c;
            end else begin
                a_r <= a_r;
                b_r <= b_r;
                c_r <= c_r;
            end
        end
    end

    // Counters, pointers, registered head and the sticky spurious flag.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            inflight_r  <= {CW{1'b0}};
            fifo_cnt_r  <= {CW{1'b0}};
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            res_valid_r <= 1'b0;
            res_data_r  <= 32'h0000_0000;
            err_r       <= 1'b0;
        end else begin
            inflight_r  <= inflight_nxt_s;
            fifo_cnt_r  <= fifo_cnt_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            res_valid_r <= (fifo_cnt_nxt_s != {CW{1'b0}});
            res_data_r  <= head_nxt_s;
            err_r       <= err_r || spurious_s;
        end
    end

    // Result storage; contents are only observed through the head register.
    always_ff @(posedge aclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= s_axis_result_tdata;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign op_ready          = op_ready_s;
    assign m_axis_a_tdata    = a_r;
    assign m_axis_b_tdata    = b_r;
    assign m_axis_c_tdata    = c_r;
    assign m_axis_abc_tvalid = tvalid_r;
    assign res_valid         = res_valid_r;
    assign res_data          = res_data_r;
    assign inflight          = inflight_r;
    assign err_spurious      = err_r;

endmodule

// File: tb/tb_fpu_muladd_issuer.sv
// tb_fpu_muladd_issuer: directed bench with a latency-programmable FPU
// model, a reference model of credits/occupancy and a result scoreboard.
module tb_fpu_muladd_issuer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [31:0]   op_a = 32'h0;
    logic [31:0]   op_b = 32'h0;
    logic [31:0]   op_c = 32'h0;
    logic [31:0]   m_axis_a_tdata;
    logic [31:0]   m_axis_b_tdata;
    logic [31:0]   m_axis_c_tdata;
    logic          m_axis_abc_tvalid;
    logic          fpu_tv;
    logic [31:0]   fpu_td;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [31:0]   res_data;
    logic [CW-1:0] inflight;
    logic          err_spurious;

    fpu_muladd_issuer #(.DEPTH(DEPTH)) dut (
        .aclk                 (aclk),
        .areset               (areset),
        .op_valid             (op_valid),
        .op_ready             (op_ready),
        .op_a                 (op_a),
        .op_b                 (op_b),
        .op_c                 (op_c),
        .m_axis_a_tdata       (m_axis_a_tdata),
        .m_axis_b_tdata       (m_axis_b_tdata),
        .m_axis_c_tdata       (m_axis_c_tdata),
        .m_axis_abc_tvalid    (m_axis_abc_tvalid),
        .s_axis_result_tvalid (fpu_tv),
        .s_axis_result_tdata  (fpu_td),
        .res_valid            (res_valid),
        .res_ready            (res_ready),
        .res_data             (res_data),
        .inflight             (inflight),
        .err_spurious         (err_spurious)
    );

    always #5 aclk = ~aclk;

    // Mock FPU arithmetic: the one test-plan vector returns the real FMA
    // result (2*3+1 = 7.0), everything else a data-dependent hash.
    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
        if (a == 32'h4000_0000 && b == 32'h4040_0000 && c == 32'h3F80_0000)
            return 32'h40E0_0000;
        return (a * 32'd5) ^ {b[7:0], b[31:8]} ^ (c + 32'h9E37_79B9);
    endfunction

    // ---------------- FPU model: valid-only delay line ----------------
    int          lat = 3;          // cycles from accept edge to result sample edge
    logic [7:0]  sr_v = 8'h00;
    logic [31:0] sr_d [0:7];
    logic        inj_v = 1'b0;
    logic [31:0] inj_d = 32'h0;

    assign fpu_tv = sr_v[lat-2] | inj_v;
    assign fpu_td = inj_v ? inj_d : sr_d[lat-2];

    // ---------------- reference model + scoreboard ----------------
    int          mdl_inf = 0;
    int          mdl_cnt = 0;
    logic        mdl_tv  = 1'b0;
    logic        mdl_err = 1'b0;
    logic [31:0] mdl_a = 32'h0, mdl_b = 32'h0, mdl_c = 32'h0;
    logic [31:0] exp_q [$];

    // Model of the issuer and the FPU pipeline, cleared with the DUT.
    always @(posedge aclk or posedge areset) begin : model
        bit acc_m, ret_m, pop_m;
        if (areset) begin
            mdl_inf <= 0;
            mdl_cnt <= 0;
            mdl_tv  <= 1'b0;
            mdl_err <= 1'b0;
            mdl_a   <= 32'h0;
            mdl_b   <= 32'h0;
            mdl_c   <= 32'h0;
            sr_v    <= 8'h00;
            exp_q.delete();
        end else begin
            acc_m = op_valid && ((mdl_inf + mdl_cnt) < DEPTH);
            ret_m = fpu_tv && (mdl_inf != 0);
            pop_m = (mdl_cnt != 0) && res_ready;
            if (fpu_tv && mdl_inf == 0) mdl_err <= 1'b1;
            mdl_inf <= mdl_inf + int'(acc_m) - int'(ret_m);
            mdl_cnt <= mdl_cnt + int'(ret_m) - int'(pop_m);
            mdl_tv  <= acc_m;
            if (acc_m) begin
                mdl_a <= op_a;
                mdl_b <= op_b;
                mdl_c <= op_c;
                exp_q.push_back(fpu_fn(op_a, op_b, op_c));
            end
            if (pop_m) void'(exp_q.pop_front());
            sr_v[0] <= m_axis_abc_tvalid;
            sr_d[0] <= fpu_fn(m_axis_a_tdata, m_axis_b_tdata, m_axis_c_tdata);
            for (int i = 1; i < 8; i++) begin
                sr_v[i] <= sr_v[i-1];
                sr_d[i] <= sr_d[i-1];
            end
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int n_res = 0;
    int n_acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: full compare against the model at negedge, then advance.
    task automatic step();
        logic [31:0] exp_head;
        @(negedge aclk);
        if (res_valid && res_ready) n_res++;
        exp_head = (mdl_cnt != 0 && exp_q.size() != 0) ? exp_q[0] : 32'h0;
        chk("op_ready", 32'(op_ready), 32'(!areset && ((mdl_inf + mdl_cnt) < DEPTH)));
        chk("inflight", 32'(inflight), 32'(mdl_inf));
        chk("tvalid",   32'(m_axis_abc_tvalid), 32'(mdl_tv));
        chk("tdata_a",  m_axis_a_tdata, mdl_a);
        chk("tdata_b",  m_axis_b_tdata, mdl_b);
        chk("tdata_c",  m_axis_c_tdata, mdl_c);
        chk("res_valid", 32'(res_valid), 32'(mdl_cnt != 0));
        chk("res_data", res_data, exp_head);
        chk("err_spurious", 32'(err_spurious), 32'(mdl_err));
        @(posedge aclk);
        #2;
    endtask

    // Offer one random triple for a cycle; a held triple is kept until taken.
    bit pending = 1'b0;
    task automatic offer();
        bit took;
        if (!pending) begin
            op_a = $urandom;
            op_b = $urandom;
            op_c = $urandom;
            pending = 1'b1;
        end
        op_valid = 1'b1;
        took = op_ready;
        step();
        if (took) begin
            pending = 1'b0;
            n_acc++;
        end
    endtask

    task automatic drain(input int cycles);
        op_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        int n;
        int base;
        bit rr_set;

        // ---- reset state ----
        #2;
        chk("rst_op_ready", 32'(op_ready), 32'h0);
        chk("rst_tvalid",   32'(m_axis_abc_tvalid), 32'h0);
        chk("rst_tdata_a",  m_axis_a_tdata, 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_res_data", res_data, 32'h0);
        chk("rst_inflight", 32'(inflight), 32'h0);
        chk("rst_err",      32'(err_spurious), 32'h0);
        step();
        step();
        areset = 1'b0;
        step();

        // ---- single op, latency 3 ----
        lat = 3;
        res_ready = 1'b0;
        op_a = 32'h4000_0000; op_b = 32'h4040_0000; op_c = 32'h3F80_0000;
        op_valid = 1'b1;
        chk("single_ready", 32'(op_ready), 32'h1);
        step();
        op_valid = 1'b0;
        n = 0;
        while (inflight != 0 && n < 10) begin
            n++;
            step();
        end
        chk("single_inflight_cycles", 32'(n), 32'd3);
        chk("single_valid", 32'(res_valid), 32'h1);
        chk("single_data", res_data, 32'h40E0_0000);
        chk("single_err", 32'(err_spurious), 32'h0);
        drain(4);

        // ---- streaming: L+2 <= DEPTH, 16 back-to-back ops ----
        lat = 2;
        res_ready = 1'b1;
        base = n_res;
        n_acc = 0;
        for (int i = 0; i < 16; i++) begin
            chk("stream_ready", 32'(op_ready), 32'h1);
            offer();
        end
        drain(10);
        chk("stream_accepts", 32'(n_acc), 32'd16);
        chk("stream_results", 32'(n_res - base), 32'd16);

        // ---- back-pressure: 10 ops, consumer stalled ----
        lat = 3;
        res_ready = 1'b0;
        base = n_res;
        n_acc = 0;
        for (int i = 0; i < 12; i++) offer();
        chk("bp_accepts", 32'(n_acc), 32'd4);
        chk("bp_ready_low", 32'(op_ready), 32'h0);
        chk("bp_inflight", 32'(inflight), 32'h0);
        res_ready = 1'b1;
        n = 0;
        while (n_acc < 10 && n < 80) begin
            n++;
            offer();
        end
        drain(12);
        chk("bp_all_accepted", 32'(n_acc), 32'd10);
        chk("bp_results", 32'(n_res - base), 32'd10);

        // ---- simultaneous push/pop at DEPTH-1 with wrap ----
        lat = 3;
        res_ready = 1'b0;
        base = n_res;
        n_acc = 0;
        rr_set = 1'b0;
        n = 0;
        while (n_acc < 16 && n < 120) begin
            if (!rr_set && mdl_cnt == DEPTH - 1 && mdl_inf == 1) begin
                chk("pp_inflight", 32'(inflight), 32'h1);
                chk("pp_valid", 32'(res_valid), 32'h1);
                res_ready = 1'b1;
                rr_set = 1'b1;
            end
            n++;
            offer();
        end
        drain(12);
        chk("pp_accepts", 32'(n_acc), 32'd16);
        chk("pp_results", 32'(n_res - base), 32'd16);

        // ---- spurious result with nothing outstanding ----
        inj_d = 32'hDEAD_BEEF;
        inj_v = 1'b1;
        step();
        inj_v = 1'b0;
        step();
        chk("spur_err", 32'(err_spurious), 32'h1);
        chk("spur_fifo_empty", 32'(res_valid), 32'h0);
        chk("spur_inflight", 32'(inflight), 32'h0);
        for (int i = 0; i < 3; i++) step();
        chk("spur_sticky", 32'(err_spurious), 32'h1);

        // ---- reset mid-burst: inflight=2, count=1 ----
        lat = 3;
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) offer();
        op_valid = 1'b0;
        step();
        chk("mid_inflight", 32'(inflight), 32'h2);
        chk("mid_valid", 32'(res_valid), 32'h1);
        areset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(res_valid), 32'h0);
        chk("mid_rst_tvalid", 32'(m_axis_abc_tvalid), 32'h0);
        chk("mid_rst_inflight", 32'(inflight), 32'h0);
        chk("mid_rst_ready", 32'(op_ready), 32'h0);
        chk("mid_rst_err", 32'(err_spurious), 32'h0);
        step();
        step();
        areset = 1'b0;
        pending = 1'b0;
        step();

        // ---- normal operation after release ----
        res_ready = 1'b1;
        base = n_res;
        n_acc = 0;
        offer();
        op_valid = 1'b0;
        n = 0;
        while (n_res == base && n < 20) begin
            n++;
            step();
        end
        chk("post_rst_accept", 32'(n_acc), 32'd1);
        chk("post_rst_result", 32'(n_res - base), 32'd1);
        chk("post_rst_err", 32'(err_spurious), 32'h0);
        drain(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
